// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter sharing one req/done memory port
// Fetch and load/store paths compete; ties go to the requester not granted last.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  input  logic [31:0] m_rdata,
  input  logic        m_done,
  output logic        grant_d,
  output logic        err
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] wdog;
  logic        pick_d;
  logic        grab;
  logic        finish;
  logic        expire;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grab      = 1'b0;
    finish    = 1'b0;
    expire    = 1'b0;
    // data wins when alone, or on a tie when fetch owned the port last
    pick_d    = d_req && (!i_req || !grant_d);
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grab      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (wdog == TMO) begin
          finish    = 1'b1;
          expire    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_req   <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_we    <= 4'd0;
      grant_d <= 1'b1;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      wdog    <= 16'd0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grab) begin
        m_req   <= 1'b1;
        m_addr  <= pick_d ? d_addr : i_addr;
        m_wdata <= pick_d ? d_wdata : 32'd0;
        m_we    <= pick_d ? d_we : 4'd0;
        grant_d <= pick_d;
        wdog    <= 16'd0;
      end else if (state == WAIT && !finish) begin
        wdog <= wdog + 16'd1;
      end
      if (finish) begin
        m_req <= 1'b0;
        if (grant_d) begin
          d_rdata <= expire ? 32'd0 : m_rdata;
          d_done  <= 1'b1;
        end else begin
          i_rdata <= expire ? 32'd0 : m_rdata;
          i_done  <= 1'b1;
        end
        if (expire) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Transaction-level reference: winner from the tie rule, latency from memory delay.
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req, d_req, m_done;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_req, grant_d, err;
  logic [3:0]  m_we;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_rdata(m_rdata), .m_done(m_done), .grant_d(grant_d), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        last_d;
  logic [31:0] exp_ir, exp_dr;
  logic        exp_err;

  logic        o_grant, o_idone, o_ddone, o_post_busy, o_missing, o_err;
  logic [31:0] o_addr, o_wdata, o_irdata, o_drdata;
  logic [3:0]  o_we;
  int          o_nreq, o_ndone;

  function automatic logic exp_winner(input logic ir, input logic dr);
    return (ir && dr) ? !last_d : dr;
  endfunction

  // Drives one transaction from an IDLE-cycle negedge; lat<0 means memory never answers
  task automatic txn(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic [31:0] da, input logic [31:0] dw, input logic [3:0] dwe,
                     input int lat, input logic [31:0] rd, input logic keep);
    int w;
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = dw; d_we = dwe;
    m_rdata = rd; m_done = 1'b0;
    o_missing = 1'b0; o_nreq = 0;
    do begin
      @(negedge clk);
      o_nreq++;
    end while (!m_req && o_nreq < 4);
    if (!m_req) begin
      o_missing = 1'b1;
      return;
    end
    o_grant = grant_d; o_addr = m_addr; o_wdata = m_wdata; o_we = m_we;
    o_ndone = o_nreq;
    w = 0;
    while (!(i_done || d_done) && w < TMO + 6) begin
      m_done = (w == lat);
      @(negedge clk);
      m_done = 1'b0;
      o_ndone++;
      w++;
    end
    if (!(i_done || d_done)) o_missing = 1'b1;
    o_idone = i_done; o_ddone = d_done; o_irdata = i_rdata; o_drdata = d_rdata; o_err = err;
    if (!keep) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    @(negedge clk);
    o_post_busy = i_done | d_done | m_req;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_req = 1'b0; d_req = 1'b0; m_done = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_we = 4'd0; m_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    last_d = 1'b1; exp_ir = 32'd0; exp_dr = 32'd0; exp_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL reset_m_req got %0b want 0", m_req); end
    n_cmp++; if ({i_done, d_done} !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", {i_done, d_done}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
    n_cmp++; if (grant_d !== 1'b1) begin n_bad++; $display("FAIL reset_grant got %0b want 1", grant_d); end
    n_cmp++; if ({m_addr, m_wdata, m_we} !== 68'd0) begin n_bad++; $display("FAIL reset_m_bus got %h want 0", {m_addr, m_wdata, m_we}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", {i_rdata, d_rdata}); end
  endtask

  task automatic test_single_fetch();
    txn(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    n_cmp++; if (o_missing !== 1'b0) begin n_bad++; $display("FAIL fetch_handshake got missing want complete"); end
    n_cmp++; if (o_grant !== 1'b0) begin n_bad++; $display("FAIL fetch_grant got %0b want 0", o_grant); end
    n_cmp++; if ({o_addr, o_wdata, o_we} !== {32'h100, 32'h0, 4'h0}) begin n_bad++; $display("FAIL fetch_m_bus got %h/%h/%h want 100/0/0", o_addr, o_wdata, o_we); end
    n_cmp++; if ({o_idone, o_ddone} !== 2'b10) begin n_bad++; $display("FAIL fetch_done got %b want 10", {o_idone, o_ddone}); end
    n_cmp++; if (o_irdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_rdata got %h want deadbeef", o_irdata); end
    n_cmp++; if (o_ndone !== 2) begin n_bad++; $display("FAIL fetch_latency got %0d want 2", o_ndone); end
    n_cmp++; if (o_post_busy !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse_width got busy want idle"); end
    last_d = 1'b0; exp_ir = 32'hDEADBEEF;
  endtask

  task automatic test_single_store();
    txn(1'b0, 32'h0, 1'b1, 32'h2004, 32'h12345678, 4'b1111, 1, 32'h0BAD0BAD, 1'b0);
    n_cmp++; if (o_missing !== 1'b0) begin n_bad++; $display("FAIL store_handshake got missing want complete"); end
    n_cmp++; if (o_grant !== 1'b1) begin n_bad++; $display("FAIL store_grant got %0b want 1", o_grant); end
    n_cmp++; if ({o_addr, o_wdata, o_we} !== {32'h2004, 32'h12345678, 4'hF}) begin n_bad++; $display("FAIL store_m_bus got %h/%h/%h want 2004/12345678/f", o_addr, o_wdata, o_we); end
    n_cmp++; if ({o_idone, o_ddone} !== 2'b01) begin n_bad++; $display("FAIL store_done got %b want 01", {o_idone, o_ddone}); end
    n_cmp++; if (o_ndone !== 3) begin n_bad++; $display("FAIL store_latency got %0d want 3", o_ndone); end
    n_cmp++; if (o_irdata !== exp_ir) begin n_bad++; $display("FAIL store_fetch_rdata_held got %h want %h", o_irdata, exp_ir); end
    last_d = 1'b1; exp_dr = 32'h0BAD0BAD;
  endtask

  task automatic test_tie();
    logic [31:0] rd;
    logic        w;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      rd = $urandom;
      w = exp_winner(1'b1, 1'b1);
      txn(1'b1, 32'h4000 + t, 1'b1, 32'h8000 + t, 32'h5500 + t, 4'h3, 2, rd, t < 3);
      n_cmp++; if (o_grant !== w || o_missing) begin n_bad++; $display("FAIL tie_order[%0d] got %0b want %0b", t, o_grant, w); end
      n_cmp++; if (o_nreq !== 1) begin n_bad++; $display("FAIL tie_gap[%0d] got %0d want 1", t, o_nreq); end
      n_cmp++; if ({o_idone, o_ddone} !== {!w, w}) begin n_bad++; $display("FAIL tie_done[%0d] got %b want %b", t, {o_idone, o_ddone}, {!w, w}); end
      n_cmp++; if ((w ? o_drdata : o_irdata) !== rd) begin n_bad++; $display("FAIL tie_rdata[%0d] got %h want %h", t, w ? o_drdata : o_irdata, rd); end
      n_cmp++; if (o_ndone !== 4) begin n_bad++; $display("FAIL tie_latency[%0d] got %0d want 4", t, o_ndone); end
      last_d = w;
      if (w) exp_dr = rd; else exp_ir = rd;
    end
  endtask

  task automatic test_withdraw();
    int n;
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b0; m_rdata = 32'hCAFEF00D; m_done = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_req && n < 4);
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL withdraw_grant got %0b want 1", m_req); end
    @(negedge clk);
    i_req = 1'b0;
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL withdraw_hold1 got %0b want 1", m_req); end
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL withdraw_hold2 got %0b want 1", m_req); end
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    n_cmp++; if ({i_done, d_done, m_req} !== 3'b100) begin n_bad++; $display("FAIL withdraw_done got %b want 100", {i_done, d_done, m_req}); end
    n_cmp++; if (i_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL withdraw_rdata got %h want cafef00d", i_rdata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({i_done, d_done, m_req} !== 3'b000) begin n_bad++; $display("FAIL withdraw_spurious[%0d] got %b want 000", c, {i_done, d_done, m_req}); end
    end
    last_d = 1'b0; exp_ir = 32'hCAFEF00D;
  endtask

  task automatic test_random();
    logic        ir, dr, w;
    logic [31:0] ia, da, dw, rd, ew;
    logic [3:0]  dwe, ewe;
    int          lat;
    for (int t = 0; t < 30; t++) begin
      ir = 1'($urandom); dr = 1'($urandom);
      if (!ir && !dr) ir = 1'b1;
      ia = $urandom; da = $urandom; dw = $urandom; rd = $urandom;
      dwe = 4'($urandom);
      lat = $urandom_range(0, 3);
      w = exp_winner(ir, dr);
      ew = w ? dw : 32'd0;
      ewe = w ? dwe : 4'd0;
      txn(ir, ia, dr, da, dw, dwe, lat, rd, 1'b0);
      if (w) exp_dr = rd; else exp_ir = rd;
      n_cmp++; if (o_missing !== 1'b0) begin n_bad++; $display("FAIL rand_handshake[%0d] got missing want complete", t); end
      n_cmp++; if (o_grant !== w) begin n_bad++; $display("FAIL rand_grant[%0d] got %0b want %0b", t, o_grant, w); end
      n_cmp++; if (o_addr !== (w ? da : ia)) begin n_bad++; $display("FAIL rand_addr[%0d] got %h want %h", t, o_addr, w ? da : ia); end
      n_cmp++; if ({o_wdata, o_we} !== {ew, ewe}) begin n_bad++; $display("FAIL rand_wdata_we[%0d] got %h/%h want %h/%h", t, o_wdata, o_we, ew, ewe); end
      n_cmp++; if (o_ndone !== lat + 2) begin n_bad++; $display("FAIL rand_latency[%0d] got %0d want %0d", t, o_ndone, lat + 2); end
      n_cmp++; if ({o_idone, o_ddone} !== {!w, w}) begin n_bad++; $display("FAIL rand_done[%0d] got %b want %b", t, {o_idone, o_ddone}, {!w, w}); end
      n_cmp++; if ({o_irdata, o_drdata} !== {exp_ir, exp_dr}) begin n_bad++; $display("FAIL rand_rdata[%0d] got %h/%h want %h/%h", t, o_irdata, o_drdata, exp_ir, exp_dr); end
      n_cmp++; if (o_post_busy !== 1'b0) begin n_bad++; $display("FAIL rand_pulse_width[%0d] got busy want idle", t); end
      last_d = w;
    end
  endtask

  task automatic test_timeout();
    txn(1'b1, 32'h700, 1'b0, 32'h0, 32'h0, 4'h0, TMO, 32'h11112222, 1'b0);
    n_cmp++; if (o_ndone !== TMO + 2 || o_missing) begin n_bad++; $display("FAIL late_done_latency got %0d want %0d", o_ndone, TMO + 2); end
    n_cmp++; if ({o_idone, o_irdata} !== {1'b1, 32'h11112222}) begin n_bad++; $display("FAIL late_done_data got %0b/%h want 1/11112222", o_idone, o_irdata); end
    n_cmp++; if (o_err !== exp_err) begin n_bad++; $display("FAIL late_done_err got %0b want %0b", o_err, exp_err); end
    last_d = 1'b0; exp_ir = 32'h11112222;
    txn(1'b0, 32'h0, 1'b1, 32'h900, 32'h0, 4'h0, -1, 32'hA5A5A5A5, 1'b0);
    n_cmp++; if (o_ndone !== TMO + 2 || o_missing) begin n_bad++; $display("FAIL timeout_latency got %0d want %0d", o_ndone, TMO + 2); end
    n_cmp++; if ({o_ddone, o_drdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL timeout_data got %0b/%h want 1/0", o_ddone, o_drdata); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %0b want 1", o_err); end
    last_d = 1'b1; exp_dr = 32'h0; exp_err = 1'b1;
    txn(1'b1, 32'h704, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h33334444, 1'b0);
    n_cmp++; if ({o_missing, o_idone, o_irdata} !== {1'b0, 1'b1, 32'h33334444}) begin n_bad++; $display("FAIL after_timeout_service got %0b/%0b/%h want 0/1/33334444", o_missing, o_idone, o_irdata); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %0b want 1", err); end
    last_d = 1'b0; exp_ir = 32'h33334444;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    i_req = 1'b1; i_addr = 32'hB00; d_req = 1'b0; m_rdata = 32'h55667788; m_done = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_req && n < 4);
    n_cmp++; if ({m_req, grant_d} !== 2'b10) begin n_bad++; $display("FAIL midreset_grant got %b want 10", {m_req, grant_d}); end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    i_req = 1'b0;
    m_done = 1'b1;
    n_cmp++; if ({m_req, i_done, d_done, grant_d, err} !== 5'b00010) begin n_bad++; $display("FAIL midreset_state got %b want 00010", {m_req, i_done, d_done, grant_d, err}); end
    @(negedge clk);
    m_done = 1'b0;
    n_cmp++; if ({m_req, i_done, d_done, i_rdata} !== 35'd0) begin n_bad++; $display("FAIL midreset_stale_done got %b/%h want 000/0", {m_req, i_done, d_done}, i_rdata); end
    @(negedge clk);
    n_cmp++; if ({m_req, i_done, d_done} !== 3'b000) begin n_bad++; $display("FAIL midreset_quiet got %b want 000", {m_req, i_done, d_done}); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_single_store();
    test_tie();
    test_withdraw();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester, single-port memory arbiter for the methane RV32I core. It shares one memory port, with a req/done handshake, between the instruction-fetch path and the load/store path. It arbitrates round-robin on ties, latches the winning request, and waits for the memory's completion pulse. It then returns read data and a one-cycle done pulse to the winner. A watchdog flags a memory that never answers.

## Interface
- `TIMEOUT`, default 255: cycles in WAIT without `m_done` before the transaction is aborted (1..65535).
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  fetch request; level, held until `i_done`.
- `i_addr`  in  32  fetch byte address.
- `i_rdata`  out  32  fetch read data; valid while `i_done`=1, held until next fetch completion.
- `i_done`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  load/store request; level, held until `d_done`.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_we`  in  4  byte write enables; 0 = load.
- `d_rdata`  out  32  load data; valid while `d_done`=1, held until next data completion.
- `d_done`  out  1  one-cycle data completion pulse.
- `m_req`  out  1  memory request, high for the whole WAIT state.
- `m_addr`, `m_wdata`  out  32 each  latched address and store data; 0 for fetch `m_wdata`.
- `m_we`  out  4  latched byte enables; 0 for fetch.
- `m_rdata`  in  32  memory read data, sampled with `m_done`.
- `m_done`  in  1  memory completion pulse; ignored outside WAIT.
- `grant_d`  out  1  current/last owner: 1 = data, 0 = fetch.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, WAIT, DONE. Reset enters IDLE.
- IDLE:
  - With any req high, pick the winner.
  - If only one req is high, that requester wins.
  - If both are high, the winner is the requester not granted last (`grant_d` inverted).
  - Latch the winner's addr/wdata/we into `m_*`, set `grant_d`, set `m_req`<=1, clear the watchdog counter, go to WAIT.
- WAIT:
  - On `m_done`=1: `m_req`<=0, copy `m_rdata` to the winner's rdata register, winner's done<=1, go to DONE.
  - Otherwise, increment the watchdog counter. When it reaches `TIMEOUT`, treat it as completion with rdata=0 and set `err`<=1.
- DONE: done pulses<=0, go to IDLE. Req levels are not sampled in DONE.
- The requester must drop req at the edge ending the DONE cycle. A req still high in IDLE is a new transaction.
- Requester dropping req during WAIT: the transaction still completes and done still pulses. Loser request inputs may change freely.
- Stores (`d_we`≠0) also capture `m_rdata` into `d_rdata`; the value is don't-care.
- `m_addr`/`m_wdata`/`m_we` stay stable from the IDLE→WAIT edge until the next grant; they are not cleared at completion.
- Only one of `i_done`/`d_done` is high in any cycle.

## Timing
- Reset values: `m_req`, `i_done`, `d_done`, `err` = 0. `m_addr`, `m_wdata`, `m_we`, `i_rdata`, `d_rdata` = 0. `grant_d` = 1, so fetch wins the first tie. Watchdog = 0.
- Reset asserted mid-transaction: next edge returns to IDLE with reset values. No done pulse and no `err` change beyond clearing.
- Edge 1 samples req in IDLE; `m_req` is high from edge 1.
- `m_done` is sampled at edge k≥2. Done is high in cycle k..k+1 with rdata valid. IDLE resumes at edge k+2.
- Minimum request-to-done latency: 2 edges. Minimum occupancy: 3 cycles per transaction.
- Back-to-back ties alternate: fetch, data, fetch…
- Timeout: `m_done` absent for `TIMEOUT` consecutive WAIT cycles → done pulse on the following edge. `err` rises on the same edge.
- `m_done` arriving on the timeout edge counts as a normal completion: real data, no `err`.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=0x100. Memory returns 0xDEADBEEF one cycle after `m_req`. Expect `m_addr`=0x100, `m_we`=0, `i_done` one cycle, `i_rdata`=0xDEADBEEF, `d_done` never high.
- Single store: `d_req`, `d_addr`=0x2004, `d_wdata`=0x12345678, `d_we`=0b1111. Expect `m_*` matching, `d_done` pulse, `grant_d`=1.
- Tie after reset: both req high continuously, memory answers after 3 cycles. Expect grant order fetch, data, fetch, data, with exactly 1 cycle between DONE and the next `m_req`.
- Timeout with `TIMEOUT`=8: `m_done` is never asserted. Expect the done pulse after 8 WAIT cycles, rdata=0, `err`=1 held, and the next request still serviced.
- Request withdrawn: `i_req` is dropped 1 cycle into WAIT. Expect `m_req` held until `m_done`, `i_done` still pulses, no spurious new grant.
- Reset mid-WAIT: assert `rstn`=0 for 1 cycle during WAIT. Expect `m_req`=0, no done, `grant_d`=1, and a pending `m_done` after reset ignored.
